// File: rtl/ppu_pkg.sv
// Shared PPU definitions: CPU register indices, VRAM port FSM states and
// the palette window base address used by the optional direct palette read.
package ppu_pkg;

  // CPU register indices, relative to $2000
  localparam logic [2:0] PPU_REG_STATUS = 3'd2;
  localparam logic [2:0] PPU_REG_SCROLL = 3'd5;
  localparam logic [2:0] PPU_REG_ADDR   = 3'd6;
  localparam logic [2:0] PPU_REG_DATA   = 3'd7;

  // Start of the palette window ($3F00-$3FFF)
  localparam logic [13:0] PPU_PALETTE_BASE = 14'h3F00;

  // VRAM transaction state
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_WAIT = 2'd1,
    ST_RD_WAIT = 2'd2
  } vram_state_e;

  // True when a (zero-extended) VRAM address falls in the palette window
  function automatic logic is_palette_addr(input logic [15:0] addr);
    return addr[15:8] == {2'b00, PPU_PALETTE_BASE[13:8]};
  endfunction

endpackage

// File: rtl/ppu_vaddr_counter.sv
// PPUADDR pointer: loaded a byte at a time from $2006 writes and advanced by
// 1 or INC_BIG after every accepted $2007 access. Wraps modulo 2^ADDR_W.
// Supports 9 <= ADDR_W <= 16.
module ppu_vaddr_counter #(
  parameter int ADDR_W  = 14,
  parameter int INC_BIG = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_hi,
  input  logic              load_lo,
  input  logic [7:0]        data,
  input  logic              inc,
  input  logic              inc_big,
  output logic [ADDR_W-1:0] vaddr
);

  logic [ADDR_W-1:0] r_vaddr;
  logic [ADDR_W-1:0] w_step;

  assign w_step = inc_big ? ADDR_W'(INC_BIG) : ADDR_W'(1);
  assign vaddr  = r_vaddr;

  // Pointer register: byte loads from $2006, wrapping increment from $2007
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vaddr <= '0;
    end else if (load_hi) begin
      r_vaddr[ADDR_W-1:8] <= data[ADDR_W-9:0];
    end else if (load_lo) begin
      r_vaddr[7:0] <= data;
    end else if (inc) begin
      r_vaddr <= r_vaddr + w_step;
    end
  end

endmodule

// File: rtl/ppu_vram_port.sv
// CPU-facing PPU register port: $2005 scroll, $2006 address, $2007 data and
// the $2002 read side effect. Drives buffered VRAM reads/writes to the PPU
// memory arbiter over a req/ack handshake.
//
// Handshake: vram_req rises the cycle after an accepted $2007 strobe and is
// held (with vram_addr/vram_we/vram_wdata stable) until the arbiter pulses
// vram_ack for one cycle; vram_rdata is valid in the ack cycle. The FSM
// returns to IDLE on the ack edge, so req is low for at least one cycle
// between transactions.
//
// Optional feature macro: PPU_PALETTE_DIRECT_READ_EN -- reads inside the
// palette window return vram_rdata on ack instead of the delayed buffer.
module ppu_vram_port
  import ppu_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int INC_BIG = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        cpu_sel,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_busy,
  output logic              cpu_overrun,
  input  logic [7:0]        ppu_ctrl1,
  output logic [15:0]       cpu_scroll_addr,
  output logic              vram_req,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_rdata,
  input  logic              vram_ack,
  output logic [1:0]        dbg_state,
  output logic [ADDR_W-1:0] dbg_vaddr
);

  vram_state_e       r_state;
  vram_state_e       w_state_nxt;
  logic              w_busy;

  logic              r_toggle;
  logic              r_overrun;
  logic [15:0]       r_scroll;
  logic              r_vram_we;
  logic [ADDR_W-1:0] r_vram_addr;
  logic [7:0]        r_vram_wdata;
  logic [7:0]        r_read_buf;
  logic [7:0]        r_cpu_rdata;

  logic              w_wr;
  logic              w_rd;
  logic              w_data_acc;
  logic              w_accept;
  logic              w_drop;
  logic              w_scroll_wr;
  logic              w_addr_wr;
  logic              w_status_rd;
  logic              w_rd_done;
  logic [ADDR_W-1:0] w_vaddr;
  logic              w_unused_ctrl;

  // A simultaneous read strobe is ignored when a write is present
  assign w_wr        = cpu_wr;
  assign w_rd        = cpu_rd & ~cpu_wr;
  assign w_data_acc  = (cpu_sel == PPU_REG_DATA) & (w_wr | w_rd);
  assign w_accept    = w_data_acc & ~w_busy;
  assign w_drop      = w_data_acc & w_busy;
  assign w_scroll_wr = w_wr & (cpu_sel == PPU_REG_SCROLL);
  assign w_addr_wr   = w_wr & (cpu_sel == PPU_REG_ADDR);
  assign w_status_rd = w_rd & (cpu_sel == PPU_REG_STATUS);
  assign w_rd_done   = (r_state == ST_RD_WAIT) & vram_ack;

  assign w_unused_ctrl = ^{ppu_ctrl1[7:3], ppu_ctrl1[1:0]};

  ppu_vaddr_counter #(
    .ADDR_W  (ADDR_W),
    .INC_BIG (INC_BIG)
  ) u_vaddr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_hi (w_addr_wr & ~r_toggle),
    .load_lo (w_addr_wr &  r_toggle),
    .data    (cpu_wdata),
    .inc     (w_accept),
    .inc_big (ppu_ctrl1[2]),
    .vaddr   (w_vaddr)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and busy/request decode; ack outside a WAIT state is ignored
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_wr ? ST_WR_WAIT : ST_RD_WAIT;
        end
      end
      ST_WR_WAIT, ST_RD_WAIT: begin
        w_busy = 1'b1;
        if (vram_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shared $2005/$2006 write toggle; a $2002 read resets it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_toggle <= 1'b0;
    end else if (w_scroll_wr | w_addr_wr) begin
      r_toggle <= ~r_toggle;
    end else if (w_status_rd) begin
      r_toggle <= 1'b0;
    end
  end

  // Sticky overrun flag: set by a dropped $2007 access, cleared by $2002 read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (w_status_rd) begin
      r_overrun <= 1'b0;
    end
  end

  // Scroll word: first $2005 write is X (low byte), second is Y (high byte)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scroll <= '0;
    end else if (w_scroll_wr) begin
      if (r_toggle) begin
        r_scroll[15:8] <= cpu_wdata;
      end else begin
        r_scroll[7:0] <= cpu_wdata;
      end
    end
  end

  // Transaction latch: held stable for the whole time vram_req is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vram_we    <= 1'b0;
      r_vram_addr  <= '0;
      r_vram_wdata <= '0;
    end else if (w_accept) begin
      r_vram_we   <= w_wr;
      r_vram_addr <= w_vaddr;
      if (w_wr) begin
        r_vram_wdata <= cpu_wdata;
      end
    end
  end

  // One-deep read buffer, refilled by every completed VRAM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_buf <= '0;
    end else if (w_rd_done) begin
      r_read_buf <= vram_rdata;
    end
  end

`ifdef PPU_PALETTE_DIRECT_READ_EN
  logic r_pal_rd;
  logic w_pal_hit;

  assign w_pal_hit = is_palette_addr(16'(w_vaddr));

  // Remember that the outstanding read targets the palette window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pal_rd <= 1'b0;
    end else if (w_accept) begin
      r_pal_rd <= w_rd & w_pal_hit;
    end
  end

  // CPU read data: buffered value on the strobe, or palette data on the ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rdata <= '0;
    end else if (w_accept & w_rd & ~w_pal_hit) begin
      r_cpu_rdata <= r_read_buf;
    end else if (w_rd_done & r_pal_rd) begin
      r_cpu_rdata <= vram_rdata;
    end
  end
`else
  // CPU read data: previous buffered value, returned on the accepted strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rdata <= '0;
    end else if (w_accept & w_rd) begin
      r_cpu_rdata <= r_read_buf;
    end
  end
`endif

  assign cpu_rdata       = r_cpu_rdata;
  assign cpu_busy        = w_busy;
  assign cpu_overrun     = r_overrun;
  assign cpu_scroll_addr = r_scroll;
  assign vram_req        = w_busy;
  assign vram_we         = r_vram_we;
  assign vram_addr       = r_vram_addr;
  assign vram_wdata      = r_vram_wdata;
  assign dbg_state       = r_state;
  assign dbg_vaddr       = w_vaddr;

endmodule

// File: tb/tb_ppu_vram_port.sv
// Bench for ppu_vram_port: directed scenarios followed by randomized CPU
// traffic against a behavioural register/VRAM model and a random-latency
// arbiter. Completed VRAM transactions are matched against an expected queue.
module tb_ppu_vram_port;

  localparam int ADDR_W  = 14;
  localparam int MEM_SZ  = 16384;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [2:0]        cpu_sel;
  logic              cpu_wr;
  logic              cpu_rd;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_busy;
  logic              cpu_overrun;
  logic [7:0]        ppu_ctrl1;
  logic [15:0]       cpu_scroll_addr;
  logic              vram_req;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_wdata;
  logic [7:0]        vram_rdata;
  logic              vram_ack;
  logic [1:0]        dbg_state;
  logic [ADDR_W-1:0] dbg_vaddr;

  ppu_vram_port #(.ADDR_W(ADDR_W), .INC_BIG(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_sel         (cpu_sel),
    .cpu_wr          (cpu_wr),
    .cpu_rd          (cpu_rd),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .cpu_busy        (cpu_busy),
    .cpu_overrun     (cpu_overrun),
    .ppu_ctrl1       (ppu_ctrl1),
    .cpu_scroll_addr (cpu_scroll_addr),
    .vram_req        (vram_req),
    .vram_we         (vram_we),
    .vram_addr       (vram_addr),
    .vram_wdata      (vram_wdata),
    .vram_rdata      (vram_rdata),
    .vram_ack        (vram_ack),
    .dbg_state       (dbg_state),
    .dbg_vaddr       (dbg_vaddr)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_bad    = 0;
  logic [22:0] exp_q[$];   // {we, addr[13:0], wdata}
  logic [7:0]  vram_mem [0:MEM_SZ-1];
  int          arb_wait = 0;
  int          arb_cnt  = 0;
  bit          chk_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_vaddr;
  bit         m_toggle, m_overrun, m_busy, m_we, m_pal, m_busy_now;
  int         m_addr;
  logic [7:0] m_wdata, m_rdata, m_read_buf;
  logic [15:0] m_scroll;

  task automatic model_reset();
    m_vaddr = 0; m_toggle = 0; m_overrun = 0; m_busy = 0; m_we = 0; m_pal = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0; m_read_buf = 0; m_scroll = 0;
    exp_q.delete();
  endtask

  function automatic int step_size();
    return ppu_ctrl1[2] ? 32 : 1;
  endfunction

  function automatic bit in_palette(input int a);
`ifdef PPU_PALETTE_DIRECT_READ_EN
    return (a >= 'h3F00) && (a <= 'h3FFF);
`else
    return (a < 0);
`endif
  endfunction

  // Model advances once per clock on the inputs seen at that edge
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        m_busy_now = m_busy;
        if (m_busy_now && vram_ack) begin
          if (!m_we) begin
            m_read_buf = vram_rdata;
            if (m_pal) m_rdata = vram_rdata;
          end
          m_busy = 0;
        end
        if (cpu_wr) begin
          if (cpu_sel == 3'd5) begin
            if (m_toggle) m_scroll[15:8] = cpu_wdata;
            else          m_scroll[7:0]  = cpu_wdata;
            m_toggle = !m_toggle;
          end else if (cpu_sel == 3'd6) begin
            if (m_toggle) m_vaddr = (m_vaddr / 256) * 256 + int'(cpu_wdata);
            else          m_vaddr = (int'(cpu_wdata) % 64) * 256 + (m_vaddr % 256);
            m_toggle = !m_toggle;
          end else if (cpu_sel == 3'd7) begin
            if (m_busy_now) m_overrun = 1;
            else begin
              exp_q.push_back({1'b1, 14'(m_vaddr), cpu_wdata});
              m_we = 1; m_addr = m_vaddr; m_wdata = cpu_wdata; m_busy = 1; m_pal = 0;
              m_vaddr = (m_vaddr + step_size()) % MEM_SZ;
            end
          end
        end else if (cpu_rd) begin
          if (cpu_sel == 3'd2) begin
            m_toggle = 0; m_overrun = 0;
          end else if (cpu_sel == 3'd7) begin
            if (m_busy_now) m_overrun = 1;
            else begin
              exp_q.push_back({1'b0, 14'(m_vaddr), 8'h00});
              m_pal = in_palette(m_vaddr);
              if (!m_pal) m_rdata = m_read_buf;
              m_we = 0; m_addr = m_vaddr; m_busy = 1;
              m_vaddr = (m_vaddr + step_size()) % MEM_SZ;
            end
          end
        end
      end
    end
  end

  // Per-cycle output comparison on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        check_eq("busy",     cpu_busy,        m_busy);
        check_eq("req",      vram_req,        m_busy);
        check_eq("idle_st",  dbg_state == 0,  !m_busy);
        check_eq("overrun",  cpu_overrun,     m_overrun);
        check_eq("scroll",   cpu_scroll_addr, m_scroll);
        check_eq("rdata",    cpu_rdata,       m_rdata);
        check_eq("vaddr",    dbg_vaddr,       m_vaddr);
        check_eq("v_addr",   vram_addr,       m_addr);
        check_eq("v_we",     vram_we,         m_we);
        check_eq("v_wdata",  vram_wdata,      m_wdata);
      end
    end
  end

  // ---------------- arbiter / VRAM model ----------------
  logic [22:0] sb_e;
  initial begin
    vram_ack = 1'b0;
    vram_rdata = 8'h00;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        vram_ack = 1'b0;
        arb_cnt = 0;
      end else begin
        #1;
        if (vram_ack) begin
          vram_ack = 1'b0;
        end else if (vram_req) begin
          if (arb_cnt >= arb_wait) begin
            arb_cnt = 0;
            check_eq("sb_depth", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              sb_e = exp_q.pop_front();
              check_eq("sb_we",   vram_we,   sb_e[22]);
              check_eq("sb_addr", vram_addr, sb_e[21:8]);
              if (sb_e[22]) check_eq("sb_wdata", vram_wdata, sb_e[7:0]);
            end
            if (vram_we) vram_mem[vram_addr] = vram_wdata;
            else         vram_rdata = vram_mem[vram_addr];
            vram_ack = 1'b1;
          end else begin
            arb_cnt++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(input logic wr, input logic rd, input logic [2:0] sel, input logic [7:0] d);
    cpu_wr = wr; cpu_rd = rd; cpu_sel = sel; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cpu_busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("idle_timeout", cpu_busy, 0);
  endtask

  // ---------------- stimulus ----------------
  int op;
  initial begin
    rst_n = 1'b0;
    cpu_sel = 3'd0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_wdata = 8'h00; ppu_ctrl1 = 8'h00;
    for (int i = 0; i < MEM_SZ; i++) vram_mem[i] = 8'($urandom);
    vram_mem[14'h2000] = 8'h55;
    idle(3);
    check_eq("rst_rdata",  cpu_rdata,       0);
    check_eq("rst_req",    vram_req,        0);
    check_eq("rst_scroll", cpu_scroll_addr, 0);
    check_eq("rst_vaddr",  dbg_vaddr,       0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // $2006 load then $2007 write with immediate ack
    cpu_op(1, 0, 3'd6, 8'h21);
    cpu_op(1, 0, 3'd6, 8'h08);
    cpu_op(1, 0, 3'd7, 8'hAB);
    check_eq("wr_req",   vram_req,   1);
    check_eq("wr_addr",  vram_addr,  14'h2108);
    check_eq("wr_we",    vram_we,    1);
    check_eq("wr_wdata", vram_wdata, 8'hAB);
    check_eq("wr_vaddr", dbg_vaddr,  14'h2109);
    wait_idle();
    check_eq("wr_mem",   vram_mem[14'h2108], 8'hAB);

    // Increment by 32 with wrap
    ppu_ctrl1 = 8'h04;
    cpu_op(1, 0, 3'd6, 8'h3F);
    cpu_op(1, 0, 3'd6, 8'hF0);
    cpu_op(1, 0, 3'd7, 8'h11);
    check_eq("wrap_addr",  vram_addr, 14'h3FF0);
    check_eq("wrap_vaddr", dbg_vaddr, 14'h0010);
    wait_idle();
    ppu_ctrl1 = 8'h00;

    // Delayed read buffer
    cpu_op(1, 0, 3'd6, 8'h20);
    cpu_op(1, 0, 3'd6, 8'h00);
    cpu_op(0, 1, 3'd7, 8'h00);
    check_eq("rd1_data", cpu_rdata, 8'h00);
    wait_idle();
    cpu_op(0, 1, 3'd7, 8'h00);
    check_eq("rd2_data", cpu_rdata, 8'h55);
    wait_idle();

    // Scroll writes and toggle reset by $2002
    cpu_op(1, 0, 3'd5, 8'h10);
    cpu_op(1, 0, 3'd5, 8'hF0);
    check_eq("scroll_xy", cpu_scroll_addr, 16'hF010);
    cpu_op(1, 0, 3'd5, 8'h33);
    cpu_op(0, 1, 3'd2, 8'h00);
    cpu_op(1, 0, 3'd5, 8'h07);
    check_eq("scroll_rst", cpu_scroll_addr, 16'hF007);

    // Simultaneous strobes: write wins (toggle now 1 -> Y byte)
    cpu_op(1, 1, 3'd5, 8'h44);
    check_eq("both_strobe", cpu_scroll_addr, 16'h4407);

    // Dropped access while ack is held off
    arb_wait = 1000;
    cpu_op(1, 0, 3'd6, 8'h21);
    cpu_op(1, 0, 3'd6, 8'h00);
    cpu_op(1, 0, 3'd7, 8'h01);
    cpu_op(1, 0, 3'd7, 8'h02);
    check_eq("ovr_set",   cpu_overrun, 1);
    check_eq("ovr_vaddr", dbg_vaddr,   14'h2101);
    arb_wait = 0;
    wait_idle();
    check_eq("ovr_mem",   vram_mem[14'h2100], 8'h01);
    cpu_op(0, 1, 3'd2, 8'h00);
    check_eq("ovr_clear", cpu_overrun, 0);

    // Asynchronous reset in RD_WAIT
    arb_wait = 1000;
    cpu_op(0, 1, 3'd7, 8'h00);
    check_eq("ar_busy", cpu_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_req",     vram_req,        0);
    check_eq("ar_busy0",   cpu_busy,        0);
    check_eq("ar_scroll",  cpu_scroll_addr, 0);
    check_eq("ar_addr",    vram_addr,       0);
    check_eq("ar_rdata",   cpu_rdata,       0);
    check_eq("ar_vaddr",   dbg_vaddr,       0);
    check_eq("ar_state",   dbg_state,       0);
    arb_wait = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      arb_wait = $urandom_range(0, 3);
      ppu_ctrl1 = 8'($urandom);
      op = $urandom_range(0, 9);
      case (op)
        0, 1: cpu_op(1, 0, 3'd5, 8'($urandom));
        2, 3: cpu_op(1, 0, 3'd6, 8'($urandom));
        4, 5: cpu_op(1, 0, 3'd7, 8'($urandom));
        6, 7: cpu_op(0, 1, 3'd7, 8'h00);
        8:    cpu_op(0, 1, 3'd2, 8'h00);
        default: cpu_op(1, 1, 3'($urandom_range(0, 7)), 8'($urandom));
      endcase
      idle($urandom_range(0, 2));
    end
    arb_wait = 0;
    wait_idle();
    idle(2);
    check_eq("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
